mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single-port data memory (`memoryFile`) between the processor's load/store path (port 0) and a loader/debug master (port 1). It accepts one request at a time through a valid/ready handshake. It drives the memory address, write-enable and write-data from registered state, and returns read data or a write acknowledgment to the granted port after a fixed memory latency. It sits between `processor` and `memoryFile` and replaces the direct wiring between them.

## Interface
Parameters:
- `ADDR_W`, 32, memory address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, cycles from address presentation to valid `mem_rdata`; legal range is 1–15

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  2  per-port request valid; bit i belongs to port i
- `req_we`  in  2  per-port write flag; 1 = write, 0 = read
- `req_addr0`, `req_addr1`  in  ADDR_W  per-port address
- `req_wdata0`, `req_wdata1`  in  DATA_W  per-port write data
- `req_ready`  out  2  per-port accept
- `rsp_valid`  out  2  per-port one-cycle response pulse
- `rsp_rdata`  out  DATA_W  response data, shared by both ports and qualified by `rsp_valid`
- `mem_address`  out  ADDR_W  memory address
- `mem_we`  out  1  memory write enable
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - Computes the grant combinationally from `req_valid`.
  - Asserts `req_ready` for the granted port only; at most one bit of `req_ready` is ever high.
  - A handshake occurs when `req_valid[i] & req_ready[i]`.
  - On a handshake the block latches owner, we, addr and wdata, loads the latency counter with MEM_LAT, and moves to BUSY.
- **BUSY**
  - `mem_address` and `mem_wdata` come from the latched values.
  - `mem_we` equals the latched we during the first BUSY cycle only and is 0 in all later cycles.
  - The counter decrements every cycle.
  - When the counter reaches 1, the block captures `mem_rdata` (reads) or 0 (writes) into the response register and moves to RESP.
- **RESP**
  - `rsp_valid[owner]` is 1 for exactly one cycle.
  - `rsp_rdata` holds the captured value.
  - The state then returns to IDLE.
- **Round-robin grant**
  - A `last` bit records the most recently granted port.
  - If only one port is valid, that port is granted.
  - If both ports are valid, the port not equal to `last` is granted.
  - `last` updates on each handshake.
  - `last` resets to 1, so port 0 wins the first contention.
- **Requester rules**
  - A requester holds valid, we, addr and wdata stable until ready.
  - A requester must not drop valid before the handshake. The block does not check this.
- **Idle outputs**
  - Outside BUSY, `mem_we`=0.
  - `mem_address` and `mem_wdata` hold their last latched values.
- **Reset** (asynchronous, also mid-transaction):
  - State returns to IDLE; `last`=1.
  - All registered outputs are 0: `mem_we`, `mem_address`, `mem_wdata`, `rsp_valid`, `rsp_rdata`.
  - The in-flight transaction is dropped with no response.
  - `req_ready` follows IDLE grant logic once `rst` deasserts.
- **Width rule:** the latency counter is 4 bits wide.

## Timing
- Handshake in cycle T:
  - BUSY occupies T+1 through T+MEM_LAT.
  - `rsp_valid` is high in cycle T+MEM_LAT+1.
  - IDLE returns at T+MEM_LAT+2, so the earliest next handshake is in that cycle.
- Throughput is one transaction per MEM_LAT+2 cycles.
- Write data reaches memory at the T+1 clock edge.
- `req_ready` is combinational from `req_valid` and the state; there is no combinational path from `mem_rdata` to any output.
- A request arriving during BUSY or RESP waits, with ready=0, until IDLE.

## Configuration
- Macro `MEM_ARB_FIXED_PRIO_EN`.
- Defined: port 0 always wins contention, and `last` is not implemented.
- Undefined: round-robin as described above.
- The handshake, latency and reset behaviour are identical in both builds.

## Structure
- `mem_arb_pkg` holds:
  - the state typedef (IDLE/BUSY/RESP)
  - the port-index constants PORT_CPU=0 and PORT_LDR=1
  - the counter width constant LAT_W=4
- One sub-module, `mem_arb_pick`: combinational 2-way grant logic taking `req_valid` and `last` and returning a one-hot grant. This is the only place the macro applies.

## Test plan
- **Single read, port 0:** MEM_LAT=1; memory holds 0xDEADBEEF at 0x10; `req_valid`=01, addr 0x10, we=0 → handshake at T; `mem_address`=0x10 at T+1; `rsp_valid`=01 with `rsp_rdata`=0xDEADBEEF at T+2.
- **Write then read, port 1:** write 0x12345678 to 0x20 → `mem_we`=1 for exactly one cycle and `rsp_valid`=10 with data 0. A following read of 0x20 returns 0x12345678.
- **Contention:** both ports hold reads continuously for 4 transactions → grants alternate 0,1,0,1; `req_ready` is never 11; each port gets exactly one `rsp_valid` pulse per grant.
- **Latency:** MEM_LAT=3 → `rsp_valid` 4 cycles after the handshake; next handshake 5 cycles after the first.
- **Reset mid-op:** assert `rst` during BUSY with a write in flight → `mem_we` goes to 0 immediately; no `rsp_valid`; after release, port 0 wins the first contention.
- **Fixed priority:** with `MEM_ARB_FIXED_PRIO_EN` defined and both ports valid for 3 transactions → all three are granted to port 0; port 1 is granted only once port 0 drops valid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter slice.
// Configuration macro MEM_ARB_FIXED_PRIO_EN is consumed by mem_arb_pick only.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_LDR = 1;
  localparam int unsigned LAT_W    = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational two-way grant, one-hot output.
// Macro MEM_ARB_FIXED_PRIO_EN: defined -> port 0 always wins contention and
// `last` is ignored; undefined -> round-robin against `last`.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last,
  output logic [1:0] grant
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  // Fixed priority: CPU port first, loader only when CPU is quiet.
  always_comb begin
    grant = '0;
    if (req_valid[PORT_CPU]) begin
      grant[PORT_CPU] = 1'b1;
    end else if (req_valid[PORT_LDR]) begin
      grant[PORT_LDR] = 1'b1;
    end
  end
`else
  // Round-robin: a lone requester wins; on contention the port that did not
  // win most recently is chosen.
  always_comb begin
    grant = '0;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port data memory between the CPU load/store
// path (port 0) and the loader/debug master (port 1). One transaction at a
// time; response returned MEM_LAT+1 cycles after the handshake.
// Grant policy selectable with MEM_ARB_FIXED_PRIO_EN (see mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(1);

  state_t           state, state_n;
  logic [1:0]       grant;
  logic             hs;
  logic             sel;
  logic             last;
  logic             owner;
  logic             we_q;
  logic [LAT_W-1:0] cnt;

  mem_arb_pick u_pick (
    .req_valid (req_valid),
    .last      (last),
    .grant     (grant)
  );

  assign sel = grant[PORT_LDR];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, ready and handshake decode.
  always_comb begin
    state_n   = state;
    req_ready = '0;
    hs        = 1'b0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (|(req_valid & grant)) begin
          hs      = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (cnt == LAT_LAST) begin
          state_n = RESP;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Transaction latch, memory drive, latency count and response capture.
  // mem_we is loaded at the handshake and cleared on the following edge, so
  // it is high for the first BUSY cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last        <= 1'b1;
      owner       <= 1'b0;
      we_q        <= 1'b0;
      cnt         <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
    end else begin
      mem_we    <= 1'b0;
      rsp_valid <= '0;
      if (hs) begin
        owner       <= sel;
        last        <= sel;
        we_q        <= req_we[sel];
        mem_we      <= req_we[sel];
        mem_address <= sel ? req_addr1 : req_addr0;
        mem_wdata   <= sel ? req_wdata1 : req_wdata0;
        cnt         <= LAT_INIT;
      end
      if (state == BUSY) begin
        cnt <= cnt - LAT_LAST;
        if (cnt == LAT_LAST) begin
          rsp_rdata <= we_q ? '0 : mem_rdata;
          rsp_valid <= owner ? 2'b10 : 2'b01;
        end
      end
    end
  end

endmodule
